pagamento_moedas: RTL and testbench

//  Coin-payment unit feeding the coffee-machine main FSM. While the main FSM sits in its

---
 rtl/pagamento_pkg.sv | 32 +++
 rtl/pagamento_moedas_if.sv | 24 ++
 rtl/detector_borda.sv | 30 +++
 rtl/pagamento_moedas.sv | 160 ++++++++++++++++
 tb/tb_pagamento_moedas.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pagamento_pkg.sv
// Shared definitions for the coin-payment unit: state encoding, PAGAR verdict codes
// and coin unit values (1 unit = R$0.25).
package pagamento_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLETA   = 3'd1,
        ST_AVALIA   = 3'd2,
        ST_APROVADO = 3'd3,
        ST_RECUSADO = 3'd4,
        ST_DEVOLVE  = 3'd5
    } estado_t;

    localparam logic [1:0] PAG_NADA = 2'b00;
    localparam logic [1:0] PAG_ERRO = 2'b01;
    localparam logic [1:0] PAG_OK   = 2'b11;

    localparam logic [2:0] MOEDA_025_U = 3'd1;
    localparam logic [2:0] MOEDA_050_U = 3'd2;
    localparam logic [2:0] MOEDA_100_U = 3'd4;

    // Value of a single-coin edge vector; zero for no coin or several at once.
    function automatic logic [2:0] valor_moeda(input logic [2:0] bordas);
        case (bordas)
            3'b001:  return MOEDA_025_U;
            3'b010:  return MOEDA_050_U;
            3'b100:  return MOEDA_100_U;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/pagamento_moedas_if.sv
// Signal bundle between the main coffee-machine FSM (master) and the payment unit (slave).
interface pagamento_moedas_if #(
    parameter int CREDIT_W = 8
);
    logic                ENABLE;
    logic [1:0]          SELECAO;
    logic [2:0]          COIN;
    logic                BOTAO_CONFIRMA;
    logic [1:0]          PAGAR;
    logic [CREDIT_W-1:0] CREDITO;
    logic [CREDIT_W-1:0] TROCO;
    logic                TROCO_VALIDO;
    logic                COIN_REJEITA;

    modport master (
        output ENABLE, SELECAO, COIN, BOTAO_CONFIRMA,
        input  PAGAR, CREDITO, TROCO, TROCO_VALIDO, COIN_REJEITA
    );

    modport slave (
        input  ENABLE, SELECAO, COIN, BOTAO_CONFIRMA,
        output PAGAR, CREDITO, TROCO, TROCO_VALIDO, COIN_REJEITA
    );
endinterface

// File: rtl/detector_borda.sv
// N-bit rising-edge detector; o_borda is a registered one-cycle pulse per 0->1 input change,
// so a held level is reported only once.
module detector_borda #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [N-1:0] i_sinal,
    output logic [N-1:0] o_borda
);
    logic [N-1:0] r_prev;
    logic [N-1:0] r_borda;
    logic [N-1:0] w_sobe;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign w_sobe[gi] = i_sinal[gi] & ~r_prev[gi];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_prev  <= '0;
            r_borda <= '0;
        end else begin
            r_prev  <= i_sinal;
            r_borda <= w_sobe;
        end
    end

    assign o_borda = r_borda;
endmodule

// File: rtl/pagamento_moedas.sv
// Coin-payment unit: accumulates credit while ENABLE is high, evaluates it against the
// price latched on entry, and reports the PAGAR verdict, change/refund and rejected coins.
module pagamento_moedas
    import pagamento_pkg::*;
#(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 40,
    parameter int PRICE_0    = 6,
    parameter int PRICE_1    = 8,
    parameter int PRICE_2    = 10,
    parameter int PRICE_3    = 12
) (
    input  logic               CLK,
    input  logic               RST,
    pagamento_moedas_if.slave  bus
);
    if (MAX_CREDIT + 4 >= (1 << CREDIT_W)) begin : g_erro_largura
        $error("MAX_CREDIT + 4 does not fit in CREDIT_W bits");
    end

    estado_t             r_estado;
    logic [1:0]          r_pagar;
    logic [CREDIT_W-1:0] r_credito;
    logic [CREDIT_W-1:0] r_preco;
    logic [CREDIT_W-1:0] r_troco;
    logic                r_troco_valido;
    logic                r_coin_rejeita;

    logic [2:0]          w_coin_borda;
    logic [0:0]          w_conf_borda;
    logic                w_coin_any;
    logic                w_coin_um;
    logic [2:0]          w_valor;
    logic [CREDIT_W-1:0] w_soma;
    logic                w_cabe;
    logic [CREDIT_W-1:0] w_preco_sel;

    detector_borda #(.N(3)) u_borda_moeda (
        .clk     (CLK),
        .srst    (RST),
        .i_sinal (bus.COIN),
        .o_borda (w_coin_borda)
    );

    detector_borda #(.N(1)) u_borda_confirma (
        .clk     (CLK),
        .srst    (RST),
        .i_sinal (bus.BOTAO_CONFIRMA),
        .o_borda (w_conf_borda)
    );

    assign w_coin_any = |w_coin_borda;
    assign w_coin_um  = $onehot(w_coin_borda);
    assign w_valor    = valor_moeda(w_coin_borda);
    assign w_soma     = r_credito + CREDIT_W'(w_valor);
    assign w_cabe     = (w_soma <= CREDIT_W'(MAX_CREDIT));

    always_comb begin
        w_preco_sel = CREDIT_W'(PRICE_0);
        case (bus.SELECAO)
            2'd1:    w_preco_sel = CREDIT_W'(PRICE_1);
            2'd2:    w_preco_sel = CREDIT_W'(PRICE_2);
            2'd3:    w_preco_sel = CREDIT_W'(PRICE_3);
            default: w_preco_sel = CREDIT_W'(PRICE_0);
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_estado       <= ST_IDLE;
            r_pagar        <= PAG_NADA;
            r_credito      <= '0;
            r_preco        <= '0;
            r_troco        <= '0;
            r_troco_valido <= 1'b0;
            r_coin_rejeita <= 1'b0;
        end else begin
            r_troco_valido <= 1'b0;
            r_coin_rejeita <= 1'b0;

            // Coins are only accepted while collecting; anything else is bounced back.
            if (r_estado != ST_COLETA && w_coin_any) begin
                r_coin_rejeita <= 1'b1;
            end

            case (r_estado)
                ST_IDLE: begin
                    r_pagar <= PAG_NADA;
                    if (bus.ENABLE) begin
                        r_estado  <= ST_COLETA;
                        r_preco   <= w_preco_sel;
                        r_credito <= '0;
                    end
                end

                ST_COLETA: begin
                    if (!bus.ENABLE) begin
                        r_estado <= ST_DEVOLVE;
                        if (w_coin_any) begin
                            r_coin_rejeita <= 1'b1;
                        end
                    end else begin
                        // A coin arriving with confirm is credited before evaluation.
                        if (w_coin_any) begin
                            if (w_coin_um && w_cabe) begin
                                r_credito <= w_soma;
                            end else begin
                                r_coin_rejeita <= 1'b1;
                            end
                        end
                        if (w_conf_borda[0]) begin
                            r_estado <= ST_AVALIA;
                        end
                    end
                end

                ST_AVALIA: begin
                    if (r_credito >= r_preco) begin
                        r_estado <= ST_APROVADO;
                        r_pagar  <= PAG_OK;
                        r_troco  <= r_credito - r_preco;
                    end else begin
                        r_estado <= ST_RECUSADO;
                        r_pagar  <= PAG_ERRO;
                        r_troco  <= r_credito;
                    end
                    r_troco_valido <= 1'b1;
                    r_credito      <= '0;
                end

                ST_APROVADO, ST_RECUSADO: begin
                    if (!bus.ENABLE) begin
                        r_estado <= ST_IDLE;
                        r_pagar  <= PAG_NADA;
                    end
                end

                ST_DEVOLVE: begin
                    if (r_credito != '0) begin
                        r_troco        <= r_credito;
                        r_troco_valido <= 1'b1;
                    end
                    r_credito <= '0;
                    r_estado  <= ST_IDLE;
                end

                default: begin
                    r_estado <= ST_IDLE;
                    r_pagar  <= PAG_NADA;
                end
            endcase
        end
    end

    assign bus.PAGAR        = r_pagar;
    assign bus.CREDITO      = r_credito;
    assign bus.TROCO        = r_troco;
    assign bus.TROCO_VALIDO = r_troco_valido;
    assign bus.COIN_REJEITA = r_coin_rejeita;
endmodule

// File: tb/tb_pagamento_moedas.sv
// Directed bench for pagamento_moedas: inputs driven and outputs sampled on the falling edge.
module tb_pagamento_moedas;
    logic clk;
    logic rst;
    int   n_testes;
    int   n_falhas;

    pagamento_moedas_if #(.CREDIT_W(8)) bus ();

    pagamento_moedas #(
        .CREDIT_W   (8),
        .MAX_CREDIT (40),
        .PRICE_0    (6),
        .PRICE_1    (8),
        .PRICE_2    (10),
        .PRICE_3    (12)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a coin for one cycle; returns once credit/reject reflects it.
    task automatic moeda(input logic [2:0] m);
        bus.COIN = m;
        espera(1);
        bus.COIN = 3'b000;
        espera(1);
    endtask

    task automatic inicia(input logic [1:0] sel);
        bus.SELECAO = sel;
        bus.ENABLE  = 1'b1;
        espera(1);
    endtask

    // Confirm edge, then check the verdict appears exactly two cycles after it is sampled.
    task automatic confirma(input string tag, input logic [1:0] pagar_esp, input int troco_esp);
        bus.BOTAO_CONFIRMA = 1'b1;
        espera(1);
        bus.BOTAO_CONFIRMA = 1'b0;
        espera(1);
        confere({tag, "_pagar_avalia"}, bus.PAGAR, 0);
        espera(1);
        confere({tag, "_pagar"}, bus.PAGAR, pagar_esp);
        confere({tag, "_troco"}, bus.TROCO, troco_esp);
        confere({tag, "_troco_valido"}, bus.TROCO_VALIDO, 1);
        confere({tag, "_credito_zero"}, bus.CREDITO, 0);
        espera(1);
        confere({tag, "_troco_pulso"}, bus.TROCO_VALIDO, 0);
        confere({tag, "_pagar_mantem"}, bus.PAGAR, pagar_esp);
    endtask

    task automatic encerra(input string tag);
        bus.ENABLE = 1'b0;
        espera(1);
        confere({tag, "_pagar_idle"}, bus.PAGAR, 0);
        espera(1);
    endtask

    initial begin
        n_testes           = 0;
        n_falhas           = 0;
        rst                = 1'b1;
        bus.ENABLE         = 1'b0;
        bus.SELECAO        = 2'd0;
        bus.COIN           = 3'b000;
        bus.BOTAO_CONFIRMA = 1'b0;
        espera(3);
        confere("reset_pagar", bus.PAGAR, 0);
        confere("reset_credito", bus.CREDITO, 0);
        confere("reset_troco", bus.TROCO, 0);
        confere("reset_troco_valido", bus.TROCO_VALIDO, 0);
        confere("reset_rejeita", bus.COIN_REJEITA, 0);
        rst = 1'b0;
        espera(1);

        // 1: drink 1 (8u), two 1.00 coins, exact payment
        inicia(2'd1);
        moeda(3'b100);
        confere("t1_credito_4", bus.CREDITO, 4);
        moeda(3'b100);
        confere("t1_credito_8", bus.CREDITO, 8);
        confirma("t1", 2'b11, 0);
        encerra("t1");
        $display("[TB] case 1 exact payment done");

        // 2: drink 0 (6u), 0.25 + 0.50 is insufficient -> refund 3
        inicia(2'd0);
        moeda(3'b001);
        moeda(3'b010);
        confere("t2_credito_3", bus.CREDITO, 3);
        confirma("t2", 2'b01, 3);
        encerra("t2");
        $display("[TB] case 2 insufficient credit done");

        // 3: simultaneous coins rejected, held coin counted once, abort refunds 4
        inicia(2'd2);
        moeda(3'b011);
        confere("t3_rejeita_dupla", bus.COIN_REJEITA, 1);
        confere("t3_credito_inalterado", bus.CREDITO, 0);
        espera(1);
        confere("t3_rejeita_pulso", bus.COIN_REJEITA, 0);
        bus.COIN = 3'b100;
        espera(10);
        confere("t3_segura_credito", bus.CREDITO, 4);
        bus.COIN = 3'b000;
        espera(2);
        confere("t3_segura_final", bus.CREDITO, 4);
        confere("t3_segura_rejeita", bus.COIN_REJEITA, 0);
        bus.ENABLE = 1'b0;
        espera(1);
        confere("t3_devolve_sem_pulso", bus.TROCO_VALIDO, 0);
        espera(1);
        confere("t3_devolve_troco", bus.TROCO, 4);
        confere("t3_devolve_valido", bus.TROCO_VALIDO, 1);
        confere("t3_devolve_credito", bus.CREDITO, 0);
        $display("[TB] case 3 coin rejection and hold done");

        // coin while idle bounces
        moeda(3'b001);
        confere("idle_moeda_rejeita", bus.COIN_REJEITA, 1);
        confere("idle_moeda_credito", bus.CREDITO, 0);
        espera(1);

        // 4: ceiling at 40, price latched at entry despite SELECAO change
        inicia(2'd3);
        bus.SELECAO = 2'd0;
        for (int i = 0; i < 9; i++) moeda(3'b100);
        moeda(3'b010);
        confere("t4_credito_38", bus.CREDITO, 38);
        moeda(3'b100);
        confere("t4_overflow_rejeita", bus.COIN_REJEITA, 1);
        confere("t4_overflow_credito", bus.CREDITO, 38);
        moeda(3'b010);
        confere("t4_limite_credito", bus.CREDITO, 40);
        confere("t4_limite_aceita", bus.COIN_REJEITA, 0);
        confirma("t4", 2'b11, 28);
        encerra("t4");
        $display("[TB] case 4 credit ceiling done");

        // 5: abort with credit 5, then re-entry relatches a cheaper price
        inicia(2'd1);
        moeda(3'b001);
        moeda(3'b100);
        confere("t5_credito_5", bus.CREDITO, 5);
        bus.ENABLE = 1'b0;
        espera(1);
        confere("t5_devolve_pagar", bus.PAGAR, 0);
        espera(1);
        confere("t5_devolve_troco", bus.TROCO, 5);
        confere("t5_devolve_valido", bus.TROCO_VALIDO, 1);
        confere("t5_devolve_pagar_idle", bus.PAGAR, 0);
        confere("t5_devolve_credito", bus.CREDITO, 0);
        inicia(2'd0);
        moeda(3'b100);
        moeda(3'b010);
        confirma("t5_relatch", 2'b11, 0);
        encerra("t5_relatch");
        $display("[TB] case 5 abort and relatch done");

        // abort with no credit: no refund pulse
        inicia(2'd0);
        bus.ENABLE = 1'b0;
        espera(1);
        confere("zero_devolve_a", bus.TROCO_VALIDO, 0);
        espera(1);
        confere("zero_devolve_b", bus.TROCO_VALIDO, 0);

        // confirm with zero credit is refused with a zero refund
        inicia(2'd2);
        confirma("zero_confirma", 2'b01, 0);
        encerra("zero_confirma");

        // 6: reset while approved, then coin and confirm on the same cycle
        inicia(2'd0);
        moeda(3'b100);
        moeda(3'b100);
        confirma("t6", 2'b11, 2);
        rst        = 1'b1;
        bus.ENABLE = 1'b0;
        espera(1);
        confere("t6_rst_pagar", bus.PAGAR, 0);
        confere("t6_rst_credito", bus.CREDITO, 0);
        confere("t6_rst_troco_valido", bus.TROCO_VALIDO, 0);
        rst = 1'b0;
        espera(1);
        confere("t6_pos_rst_troco_valido", bus.TROCO_VALIDO, 0);
        inicia(2'd0);
        moeda(3'b100);
        bus.COIN           = 3'b010;
        bus.BOTAO_CONFIRMA = 1'b1;
        espera(1);
        bus.COIN           = 3'b000;
        bus.BOTAO_CONFIRMA = 1'b0;
        espera(1);
        confere("t6_mesmo_ciclo_pagar_avalia", bus.PAGAR, 0);
        espera(1);
        confere("t6_mesmo_ciclo_pagar", bus.PAGAR, 3);
        confere("t6_mesmo_ciclo_troco", bus.TROCO, 0);
        confere("t6_mesmo_ciclo_valido", bus.TROCO_VALIDO, 1);
        encerra("t6_mesmo_ciclo");
        $display("[TB] case 6 reset and coin-with-confirm done");

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end
endmodule
